// File: rtl/sort_checker_pkg.sv
// Shared definitions for the end-of-program sort checker: error codes and FSM state encoding.
package sort_checker_pkg;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_UNEXP_OVF   = 3'd1;
    localparam logic [2:0] ERR_MISSING_OVF = 3'd2;
    localparam logic [2:0] ERR_ORDER       = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT     = 3'd4;

    typedef enum logic [1:0] {
        WATCH = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/elem_order_cmp.sv
// Combinational neighbour-order test: flags cur as out of order relative to prev.
module elem_order_cmp #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] prev_i,
    input  logic [DATA_W-1:0] cur_i,
    input  logic              descending_i,
    input  logic              signed_cmp_i,
    input  logic              strict_i,
    output logic              violation_o
);

    logic eq;
    logic lt;
    logic gt;

    assign eq = (cur_i == prev_i);
    assign lt = signed_cmp_i ? ($signed(cur_i) < $signed(prev_i)) : (cur_i < prev_i);
    assign gt = signed_cmp_i ? ($signed(cur_i) > $signed(prev_i)) : (cur_i > prev_i);

    // Ascending forbids a drop, descending forbids a rise; strict also forbids ties.
    assign violation_o = (descending_i ? gt : lt) | (strict_i & eq);

endmodule

// File: rtl/sort_result_checker.sv
// Watches CPU PC/Overflow until the halt address, then scans a data-memory array for sort order
// and reports sticky done/pass with an error code, first failing index and a watchdog count.
module sort_result_checker
    import sort_checker_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BASE_ADDR  = 512,
    parameter int unsigned N_ELEM     = 12,
    parameter int unsigned HALT_PC    = 104,
    parameter int unsigned EXPECT_OVF = 1,
    parameter int unsigned DESCENDING = 0,
    parameter int unsigned SIGNED_CMP = 0,
    parameter int unsigned STRICT     = 1,
    parameter int unsigned READ_LAT   = 0,
    parameter int unsigned MAX_CYCLES = 0,
    localparam int unsigned IDX_W     = $clog2(N_ELEM) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              overflow_i,
    output logic              dm_rd_en_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic [2:0]        err_code_o,
    output logic [IDX_W-1:0]  err_index_o,
    output logic [31:0]       cycle_count_o
);

    // state | meaning
    // WATCH | program running; count cycles, trap overflow, wait for halt PC
    // SCAN  | issue DM reads and compare each element with its predecessor
    // DONE  | verdict latched; outputs frozen until reset

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0]  END_IDX  = IDX_W'(N_ELEM);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] HALT_A   = ADDR_W'(HALT_PC);
    localparam logic [31:0]       TMO_CNT  = 32'(MAX_CYCLES - 1);

    state_e              state_q, state_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [2:0]          err_code_q, err_code_d;
    logic [IDX_W-1:0]    err_index_q, err_index_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   prev_q, prev_d;

    logic                iss_act;
    logic                dat_vld;
    logic [IDX_W-1:0]    dat_idx;
    logic                viol;

    assign iss_act    = (state_q == SCAN) && (idx_q < END_IDX);
    assign dm_rd_en_o = iss_act;
    assign dm_addr_o  = iss_act ? (BASE_A + (ADDR_W'(idx_q) << 2)) : '0;

    // Index of the element whose data is on dm_rdata_i this cycle.
    generate
        if (READ_LAT == 0) begin : g_lat0
            assign dat_vld = (state_q == SCAN);
            assign dat_idx = idx_q;
        end else begin : g_lat1
            logic             pipe_vld_q;
            logic [IDX_W-1:0] pipe_idx_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pipe_vld_q <= 1'b0;
                    pipe_idx_q <= '0;
                end else begin
                    pipe_vld_q <= iss_act;
                    pipe_idx_q <= idx_q;
                end
            end

            assign dat_vld = pipe_vld_q && (state_q == SCAN);
            assign dat_idx = pipe_idx_q;
        end
    endgenerate

    elem_order_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .prev_i       (prev_q),
        .cur_i        (dm_rdata_i),
        .descending_i (DESCENDING != 0),
        .signed_cmp_i (SIGNED_CMP != 0),
        .strict_i     (STRICT != 0),
        .violation_o  (viol)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        cyc_d       = cyc_q;
        idx_d       = idx_q;
        prev_d      = prev_q;

        unique case (state_q)
            WATCH: begin
                idx_d = '0;
                if (pc_i == HALT_A) begin
                    if ((EXPECT_OVF != 0) && !overflow_i) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        err_code_d = ERR_MISSING_OVF;
                    end else if ((EXPECT_OVF == 0) && overflow_i) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        err_code_d = ERR_UNEXP_OVF;
                    end else begin
                        state_d = SCAN;
                    end
                end else if (overflow_i) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_code_d = ERR_UNEXP_OVF;
                end else if ((MAX_CYCLES != 0) && (cyc_q == TMO_CNT)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else if (cyc_q != '1) begin
                    cyc_d = cyc_q + 32'd1;
                end
            end

            SCAN: begin
                if (iss_act) begin
                    idx_d = idx_q + 1'b1;
                end
                if (dat_vld) begin
                    prev_d = dm_rdata_i;
                    if ((dat_idx != '0) && viol) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        err_code_d  = ERR_ORDER;
                        err_index_d = dat_idx;
                    end else if (dat_idx == LAST_IDX) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        pass_d     = 1'b1;
                        err_code_d = ERR_NONE;
                    end
                end
            end

            DONE: begin
            end

            default: begin
                state_d = WATCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WATCH;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_index_q <= '0;
            cyc_q       <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
            cyc_q       <= cyc_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
        end
    end

    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_code_o    = err_code_q;
    assign err_index_o   = err_index_q;
    assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Directed bench for sort_result_checker: several parameterisations share one PC/Overflow stimulus.
module tb_sort_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        ovf;
    logic [31:0] pc;

    always #5 clk = ~clk;

    logic [31:0] mem_a [12];
    logic [31:0] mem_d [4];

    int n_checks = 0;
    int n_pass   = 0;

    // default instance
    logic a_rd, a_done, a_pass;
    logic [31:0] a_addr, a_rdata, a_cyc, ia_a;
    logic [2:0]  a_err;
    logic [4:0]  a_idx;
    // watchdog instance
    logic w_rd, w_done, w_pass;
    logic [31:0] w_addr, w_rdata, w_cyc, ia_w;
    logic [2:0]  w_err;
    logic [4:0]  w_idx;
    // READ_LAT=1 instance
    logic l_rd, l_done, l_pass;
    logic [31:0] l_addr, l_rdata, l_cyc, ia_l;
    logic [2:0]  l_err;
    logic [4:0]  l_idx;
    // descending signed, non-strict and strict
    logic d0_rd, d0_done, d0_pass;
    logic [31:0] d0_addr, d0_rdata, d0_cyc, ia_d0;
    logic [2:0]  d0_err;
    logic [2:0]  d0_idx;
    logic d1_rd, d1_done, d1_pass;
    logic [31:0] d1_addr, d1_rdata, d1_cyc, ia_d1;
    logic [2:0]  d1_err;
    logic [2:0]  d1_idx;

    sort_result_checker u_dflt (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .overflow_i(ovf),
        .dm_rd_en_o(a_rd), .dm_addr_o(a_addr), .dm_rdata_i(a_rdata),
        .done_o(a_done), .pass_o(a_pass), .err_code_o(a_err),
        .err_index_o(a_idx), .cycle_count_o(a_cyc));

    sort_result_checker #(.MAX_CYCLES(50)) u_wdog (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .overflow_i(ovf),
        .dm_rd_en_o(w_rd), .dm_addr_o(w_addr), .dm_rdata_i(w_rdata),
        .done_o(w_done), .pass_o(w_pass), .err_code_o(w_err),
        .err_index_o(w_idx), .cycle_count_o(w_cyc));

    sort_result_checker #(.READ_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .overflow_i(ovf),
        .dm_rd_en_o(l_rd), .dm_addr_o(l_addr), .dm_rdata_i(l_rdata),
        .done_o(l_done), .pass_o(l_pass), .err_code_o(l_err),
        .err_index_o(l_idx), .cycle_count_o(l_cyc));

    sort_result_checker #(.N_ELEM(4), .DESCENDING(1), .SIGNED_CMP(1), .STRICT(0)) u_dsc0 (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .overflow_i(ovf),
        .dm_rd_en_o(d0_rd), .dm_addr_o(d0_addr), .dm_rdata_i(d0_rdata),
        .done_o(d0_done), .pass_o(d0_pass), .err_code_o(d0_err),
        .err_index_o(d0_idx), .cycle_count_o(d0_cyc));

    sort_result_checker #(.N_ELEM(4), .DESCENDING(1), .SIGNED_CMP(1), .STRICT(1)) u_dsc1 (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .overflow_i(ovf),
        .dm_rd_en_o(d1_rd), .dm_addr_o(d1_addr), .dm_rdata_i(d1_rdata),
        .done_o(d1_done), .pass_o(d1_pass), .err_code_o(d1_err),
        .err_index_o(d1_idx), .cycle_count_o(d1_cyc));

    // Memory models: combinational for READ_LAT=0, registered for READ_LAT=1.
    always @* begin
        ia_a    = a_addr - 32'd512;
        a_rdata = (ia_a < 32'd48) ? mem_a[ia_a[5:2]] : 32'd0;
        ia_w    = w_addr - 32'd512;
        w_rdata = (ia_w < 32'd48) ? mem_a[ia_w[5:2]] : 32'd0;
        ia_l    = l_addr - 32'd512;
        ia_d0   = d0_addr - 32'd512;
        d0_rdata = (ia_d0 < 32'd16) ? mem_d[ia_d0[3:2]] : 32'd0;
        ia_d1   = d1_addr - 32'd512;
        d1_rdata = (ia_d1 < 32'd16) ? mem_d[ia_d1[3:2]] : 32'd0;
    end

    always @(posedge clk) begin
        if (l_rd) l_rdata <= (ia_l < 32'd48) ? mem_a[ia_l[5:2]] : 32'd0;
    end

    logic [31:0] rd_log [$];
    always @(negedge clk) begin
        if (a_rd) rd_log.push_back(a_addr);
    end

    task automatic init_mem;
        for (int i = 0; i < 12; i++) mem_a[i] = 32'(11 * i);
        mem_d[0] = 32'd5;
        mem_d[1] = 32'd5;
        mem_d[2] = 32'd0;
        mem_d[3] = 32'hFFFF_FFFD;
    endtask

    task automatic reset_dut;
        @(posedge clk); #1;
        rst = 1'b1; pc = 32'd0; ovf = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // pc 0..100 sampled on 26 edges; pc=104 appears right after the last one (the halt edge).
    task automatic step_to_halt(input logic ovf_at_halt);
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk); #1;
            pc = 32'(4 * k);
            if (k == 26) ovf = ovf_at_halt;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; pc = 32'd104; ovf = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (a_done !== 1'b0) $display("FAIL reset_done got=%0d exp=0", a_done); else n_pass++;
        n_checks++; if (a_pass !== 1'b0) $display("FAIL reset_pass got=%0d exp=0", a_pass); else n_pass++;
        n_checks++; if (a_rd !== 1'b0) $display("FAIL reset_rd_en got=%0d exp=0", a_rd); else n_pass++;
        n_checks++; if (a_addr !== 32'd0) $display("FAIL reset_addr got=%0d exp=0", a_addr); else n_pass++;
        n_checks++; if (a_err !== 3'd0) $display("FAIL reset_err got=%0d exp=0", a_err); else n_pass++;
        n_checks++; if (a_idx !== 5'd0) $display("FAIL reset_idx got=%0d exp=0", a_idx); else n_pass++;
        n_checks++; if (a_cyc !== 32'd0) $display("FAIL reset_cyc got=%0d exp=0", a_cyc); else n_pass++;
        n_checks++; if (l_done !== 1'b0) $display("FAIL reset_l_done got=%0d exp=0", l_done); else n_pass++;
    endtask

    task automatic test_sorted_pass;
        int base;
        init_mem();
        reset_dut();
        base = rd_log.size();
        step_to_halt(1'b1);
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (c == 1) ovf = 1'b0;
            @(negedge clk);
            n_checks++; if (a_done !== (c >= 13)) $display("FAIL sorted_done_timing cyc=%0d got=%0d exp=%0d", c, a_done, (c >= 13)); else n_pass++;
            n_checks++; if (l_done !== (c >= 14)) $display("FAIL lat1_done_timing cyc=%0d got=%0d exp=%0d", c, l_done, (c >= 14)); else n_pass++;
            if (c == 12) begin
                n_checks++; if (l_rd !== 1'b1) $display("FAIL lat1_rd_last got=%0d exp=1", l_rd); else n_pass++;
            end
            if (c == 13) begin
                n_checks++; if (l_rd !== 1'b0) $display("FAIL lat1_rd_drop got=%0d exp=0", l_rd); else n_pass++;
            end
        end
        n_checks++; if (a_pass !== 1'b1) $display("FAIL sorted_pass got=%0d exp=1", a_pass); else n_pass++;
        n_checks++; if (a_err !== 3'd0) $display("FAIL sorted_err got=%0d exp=0", a_err); else n_pass++;
        n_checks++; if (a_idx !== 5'd0) $display("FAIL sorted_idx got=%0d exp=0", a_idx); else n_pass++;
        n_checks++; if (a_cyc !== 32'd26) $display("FAIL sorted_cyc got=%0d exp=26", a_cyc); else n_pass++;
        n_checks++; if (rd_log.size() - base !== 12) $display("FAIL sorted_nreads got=%0d exp=12", rd_log.size() - base); else n_pass++;
        for (int i = 0; i < 12 && base + i < rd_log.size(); i++) begin
            n_checks++;
            if (rd_log[base + i] !== 32'(512 + 4 * i)) $display("FAIL sorted_addr i=%0d got=%0d exp=%0d", i, rd_log[base + i], 512 + 4 * i);
            else n_pass++;
        end
        n_checks++; if (l_pass !== 1'b1) $display("FAIL lat1_pass got=%0d exp=1", l_pass); else n_pass++;
        n_checks++; if (l_err !== 3'd0) $display("FAIL lat1_err got=%0d exp=0", l_err); else n_pass++;
        n_checks++; if (d0_pass !== 1'b1) $display("FAIL desc_nonstrict_pass got=%0d exp=1", d0_pass); else n_pass++;
        n_checks++; if (d0_err !== 3'd0) $display("FAIL desc_nonstrict_err got=%0d exp=0", d0_err); else n_pass++;
        n_checks++; if (d1_pass !== 1'b0) $display("FAIL desc_strict_pass got=%0d exp=0", d1_pass); else n_pass++;
        n_checks++; if (d1_err !== 3'd3) $display("FAIL desc_strict_err got=%0d exp=3", d1_err); else n_pass++;
        n_checks++; if (d1_idx !== 3'd1) $display("FAIL desc_strict_idx got=%0d exp=1", d1_idx); else n_pass++;
        // Activity after DONE must not disturb the verdict.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ovf = 1'b1; pc = 32'(8 * c);
        end
        @(negedge clk);
        ovf = 1'b0;
        n_checks++; if (a_pass !== 1'b1) $display("FAIL sticky_pass got=%0d exp=1", a_pass); else n_pass++;
        n_checks++; if (a_err !== 3'd0) $display("FAIL sticky_err got=%0d exp=0", a_err); else n_pass++;
        n_checks++; if (a_done !== 1'b1) $display("FAIL sticky_done got=%0d exp=1", a_done); else n_pass++;
    endtask

    task automatic test_order_violation;
        int base;
        logic [31:0] amax;
        init_mem();
        mem_a[5] = 32'd5;
        reset_dut();
        base = rd_log.size();
        step_to_halt(1'b1);
        @(posedge clk); #1;
        ovf = 1'b0;
        for (int c = 0; c < 30 && !(a_done && l_done); c++) @(negedge clk);
        amax = 32'd0;
        for (int i = base; i < rd_log.size(); i++) if (rd_log[i] > amax) amax = rd_log[i];
        n_checks++; if (a_done !== 1'b1) $display("FAIL order_done got=%0d exp=1", a_done); else n_pass++;
        n_checks++; if (a_err !== 3'd3) $display("FAIL order_err got=%0d exp=3", a_err); else n_pass++;
        n_checks++; if (a_idx !== 5'd5) $display("FAIL order_idx got=%0d exp=5", a_idx); else n_pass++;
        n_checks++; if (a_pass !== 1'b0) $display("FAIL order_pass got=%0d exp=0", a_pass); else n_pass++;
        n_checks++; if (amax !== 32'd532) $display("FAIL order_max_addr got=%0d exp=532", amax); else n_pass++;
        n_checks++; if (rd_log.size() - base !== 6) $display("FAIL order_nreads got=%0d exp=6", rd_log.size() - base); else n_pass++;
        n_checks++; if (l_err !== 3'd3) $display("FAIL lat1_order_err got=%0d exp=3", l_err); else n_pass++;
        n_checks++; if (l_idx !== 5'd5) $display("FAIL lat1_order_idx got=%0d exp=5", l_idx); else n_pass++;
        init_mem();
    endtask

    task automatic test_unsigned_cmp;
        init_mem();
        mem_a[11] = 32'hFFFF_FFF0;
        reset_dut();
        step_to_halt(1'b1);
        @(posedge clk); #1;
        ovf = 1'b0;
        for (int c = 0; c < 30 && !a_done; c++) @(negedge clk);
        n_checks++; if (a_pass !== 1'b1) $display("FAIL unsigned_pass got=%0d exp=1", a_pass); else n_pass++;
        n_checks++; if (a_err !== 3'd0) $display("FAIL unsigned_err got=%0d exp=0", a_err); else n_pass++;
        init_mem();
    endtask

    task automatic test_unexp_ovf;
        int base;
        reset_dut();
        base = rd_log.size();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            pc = 32'(4 * k);
            if (k == 10) ovf = 1'b1;
        end
        @(negedge clk);
        n_checks++; if (a_done !== 1'b0) $display("FAIL unexp_early_done got=%0d exp=0", a_done); else n_pass++;
        @(posedge clk); #1;
        ovf = 1'b0; pc = 32'd44;
        @(negedge clk);
        n_checks++; if (a_done !== 1'b1) $display("FAIL unexp_done got=%0d exp=1", a_done); else n_pass++;
        n_checks++; if (a_err !== 3'd1) $display("FAIL unexp_err got=%0d exp=1", a_err); else n_pass++;
        n_checks++; if (a_pass !== 1'b0) $display("FAIL unexp_pass got=%0d exp=0", a_pass); else n_pass++;
        n_checks++; if (a_cyc !== 32'd10) $display("FAIL unexp_cyc got=%0d exp=10", a_cyc); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (a_cyc !== 32'd10) $display("FAIL unexp_cyc_frozen got=%0d exp=10", a_cyc); else n_pass++;
        n_checks++; if (a_idx !== 5'd0) $display("FAIL unexp_idx got=%0d exp=0", a_idx); else n_pass++;
        n_checks++; if (rd_log.size() - base !== 0) $display("FAIL unexp_nreads got=%0d exp=0", rd_log.size() - base); else n_pass++;
    endtask

    task automatic test_missing_ovf;
        int base;
        reset_dut();
        base = rd_log.size();
        step_to_halt(1'b0);
        @(negedge clk);
        n_checks++; if (a_done !== 1'b0) $display("FAIL missing_early_done got=%0d exp=0", a_done); else n_pass++;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (a_done !== 1'b1) $display("FAIL missing_done got=%0d exp=1", a_done); else n_pass++;
        n_checks++; if (a_err !== 3'd2) $display("FAIL missing_err got=%0d exp=2", a_err); else n_pass++;
        n_checks++; if (a_pass !== 1'b0) $display("FAIL missing_pass got=%0d exp=0", a_pass); else n_pass++;
        n_checks++; if (rd_log.size() - base !== 0) $display("FAIL missing_nreads got=%0d exp=0", rd_log.size() - base); else n_pass++;
    endtask

    task automatic test_timeout;
        reset_dut();
        pc = 32'd8;
        repeat (49) @(posedge clk);
        @(negedge clk);
        n_checks++; if (w_done !== 1'b0) $display("FAIL timeout_early_done got=%0d exp=0", w_done); else n_pass++;
        n_checks++; if (w_cyc !== 32'd49) $display("FAIL timeout_cyc49 got=%0d exp=49", w_cyc); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (w_done !== 1'b1) $display("FAIL timeout_done got=%0d exp=1", w_done); else n_pass++;
        n_checks++; if (w_err !== 3'd4) $display("FAIL timeout_err got=%0d exp=4", w_err); else n_pass++;
        n_checks++; if (w_cyc !== 32'd49) $display("FAIL timeout_cyc_frozen got=%0d exp=49", w_cyc); else n_pass++;
        n_checks++; if (a_done !== 1'b0) $display("FAIL no_watchdog_done got=%0d exp=0", a_done); else n_pass++;
        n_checks++; if (a_cyc !== 32'd50) $display("FAIL no_watchdog_cyc got=%0d exp=50", a_cyc); else n_pass++;
    endtask

    task automatic test_reset_mid_scan;
        init_mem();
        reset_dut();
        step_to_halt(1'b1);
        @(posedge clk); #1;
        ovf = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (l_rd !== 1'b1) $display("FAIL midscan_active got=%0d exp=1", l_rd); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (l_rd !== 1'b0) $display("FAIL midscan_rd got=%0d exp=0", l_rd); else n_pass++;
        n_checks++; if (l_addr !== 32'd0) $display("FAIL midscan_addr got=%0d exp=0", l_addr); else n_pass++;
        n_checks++; if (l_done !== 1'b0) $display("FAIL midscan_done got=%0d exp=0", l_done); else n_pass++;
        n_checks++; if (l_pass !== 1'b0) $display("FAIL midscan_pass got=%0d exp=0", l_pass); else n_pass++;
        n_checks++; if (l_err !== 3'd0) $display("FAIL midscan_err got=%0d exp=0", l_err); else n_pass++;
        n_checks++; if (l_cyc !== 32'd0) $display("FAIL midscan_cyc got=%0d exp=0", l_cyc); else n_pass++;
        rst = 1'b0; pc = 32'd0; ovf = 1'b0;
        step_to_halt(1'b1);
        @(posedge clk); #1;
        ovf = 1'b0;
        for (int c = 0; c < 30 && !l_done; c++) @(negedge clk);
        n_checks++; if (l_done !== 1'b1) $display("FAIL rehalt_done got=%0d exp=1", l_done); else n_pass++;
        n_checks++; if (l_pass !== 1'b1) $display("FAIL rehalt_pass got=%0d exp=1", l_pass); else n_pass++;
        n_checks++; if (l_err !== 3'd0) $display("FAIL rehalt_err got=%0d exp=0", l_err); else n_pass++;
        n_checks++; if (l_cyc !== 32'd26) $display("FAIL rehalt_cyc got=%0d exp=26", l_cyc); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        pc  = 32'd0;
        ovf = 1'b0;
        init_mem();
        test_reset();
        test_sorted_pass();
        test_order_violation();
        test_unsigned_cmp();
        test_unexp_ovf();
        test_missing_ovf();
        test_timeout();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/sort_result_checker.md
Name: sort_result_checker

Overview:
Synthesizable, parametrised end-of-program checker. Sits beside CPU_SingleCycle and watches its PC and Overflow. When PC reaches a halt address, it checks the overflow expectation, then scans a data-memory array through a dedicated read port to confirm ordering. It reports sticky done/pass, an error code and the first failing index, which lets self-checking runs work on FPGA as well as in simulation.

Parameters:
DATA_W, 32, element and data-port width
ADDR_W, 32, byte-address width of PC and DM read port
BASE_ADDR, 512, byte address of element 0
N_ELEM, 12, element count; must be >= 1
HALT_PC, 104, PC value that ends the program
EXPECT_OVF, 1, 1: Overflow must be 1 at halt and 0 before it; 0: Overflow must be 0 always
DESCENDING, 0, 0: ascending order required; 1: descending
SIGNED_CMP, 0, 1: two's-complement compare; 0: unsigned
STRICT, 1, 1: equal neighbours are a violation; 0: equal allowed
READ_LAT, 0, DM read latency in cycles; 0 or 1 only
MAX_CYCLES, 0, watchdog limit in cycles before halt; 0 disables

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  CPU program counter (PC register Q)
overflow  in  1  CPU Overflow
dm_rd_en  out  1  read strobe to DM second port
dm_addr  out  ADDR_W  byte address = BASE_ADDR + 4*i
dm_rdata  in  DATA_W  read data; valid same cycle (READ_LAT=0) or next cycle (READ_LAT=1)
done  out  1  sticky; check complete
pass  out  1  sticky; valid only when done=1
err_code  out  3  0 NONE, 1 UNEXP_OVF, 2 MISSING_OVF, 3 ORDER, 4 TIMEOUT
err_index  out  $clog2(N_ELEM)+1  index i of first element that violates order vs element i-1
cycle_count  out  32  cycles spent in WATCH, saturating

Behaviour:
- Reset (rst=1 at an edge): state WATCH. done, pass, dm_rd_en, dm_addr, err_code, err_index, cycle_count all go to 0. Reset takes effect from any state and aborts a scan in progress.
- WATCH, evaluated at each edge:
  - If pc==HALT_PC, go to the halt check, which has highest priority:
    - EXPECT_OVF=1 and overflow=0: err MISSING_OVF, go to DONE.
    - EXPECT_OVF=0 and overflow=1: err UNEXP_OVF, go to DONE.
    - Otherwise go to SCAN.
  - Else if overflow=1: err UNEXP_OVF, go to DONE.
  - Else if MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1: err TIMEOUT, go to DONE.
  - Else cycle_count increments and saturates at 2^32-1.
  - A halt and a timeout in the same cycle: halt wins.
- SCAN:
  - Index i runs 0..N_ELEM-1. dm_rd_en=1 and dm_addr=BASE_ADDR+4*i for each issued read. Address arithmetic is modulo 2^ADDR_W.
  - Element 0 loads the prev register. For i>=1, compare prev against the current element:
    - Ascending: violation if cur<prev, or cur==prev when STRICT=1.
    - Descending: mirrored.
    - SIGNED_CMP selects the compare type.
  - On the first violation: err ORDER, err_index=i, go to DONE immediately; remaining elements are not read.
  - READ_LAT=0: one read and one compare per cycle; a full scan takes N_ELEM cycles.
  - READ_LAT=1: reads are pipelined and data at cycle k pairs with the address from cycle k-1; a full scan takes N_ELEM+1 cycles. dm_rd_en drops after the last address is issued.
  - pc and overflow are ignored during SCAN.
  - If no violation is found: pass=1, err NONE.
  - N_ELEM=1 always passes after one read.
- DONE:
  - On entry, done=1 (the cycle after the deciding edge). pass=1 only for NONE.
  - dm_rd_en=0.
  - All outputs are held until rst; later pc or overflow activity is ignored.
- err_index is 0 unless err_code is ORDER.

Decomposition:
- Package sort_checker_pkg: err-code constants (ERR_NONE..ERR_TIMEOUT, 3 bits) and state encoding (WATCH, SCAN, DONE).
- Sub-module elem_order_cmp: combinational; inputs prev, cur, DESCENDING, SIGNED_CMP, STRICT; output violation.
- The top level holds the FSM, index counter, READ_LAT pipeline register and watchdog.

Test Plan:
- Defaults; array 0,11,22..121 at 512..556; pc steps by 4 to 104 with overflow=1 only at the halt cycle -> done=1, pass=1, err_code=0, dm_addr walks 512..556, done asserted 13 cycles after halt edge.
- Same but element 5 = 5 (below 44) -> err_code=3, err_index=5, no read issued above address 532.
- overflow pulses 1 at pc=40 -> err_code=1 next cycle, cycle_count frozen at 10, no DM reads.
- pc reaches 104 with overflow=0 -> err_code=2; separately, MAX_CYCLES=50 with pc never 104 -> err_code=4 after 50 cycles.
- DESCENDING=1, SIGNED_CMP=1, STRICT=0, data 5,5,0,-3 (N_ELEM=4) -> pass; STRICT=1 -> err_code=3, err_index=1.
- READ_LAT=1 with the sorted array -> pass, done 14 cycles after halt; rst asserted mid-SCAN -> all outputs 0 next cycle, re-halt completes normally.
